vga_pixel_fx: RTL and testbench

VGA_PIXEL_FX -- requirements
Module: vga_pixel_fx

---
 rtl/vga_fx_pkg.sv | 40 ++++
 rtl/vga_luma.sv | 52 +++++
 rtl/vga_pixel_fx.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_pixel_fx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fx_pkg.sv
// Shared definitions for the VGA pixel effects block.
// Contents:
//   fx_mode_e        - effect mode encodings as seen on i_mode / o_mode
//   LUMA_R/G/B       - BT.601-style luma weights, scaled so they sum to 256
//   bar_rgb()        - colour-bar table, index -> {red, green, blue} on/off bits
package vga_fx_pkg;

    typedef enum logic [2:0] {
        MODE_PASS   = 3'd0,
        MODE_INV    = 3'd1,
        MODE_GRAY   = 3'd2,
        MODE_THRESH = 3'd3,
        MODE_BARS   = 3'd4,
        MODE_CHECK  = 3'd5,
        MODE_RSV6   = 3'd6,
        MODE_RSV7   = 3'd7
    } fx_mode_e;

    // 77 + 150 + 29 = 256, so full-scale input gives full-scale luma.
    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    // Classic SMPTE-like bar order, brightest first.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111; // white
            3'd1:    rgb = 3'b110; // yellow
            3'd2:    rgb = 3'b011; // cyan
            3'd3:    rgb = 3'b010; // green
            3'd4:    rgb = 3'b101; // magenta
            3'd5:    rgb = 3'b100; // red
            3'd6:    rgb = 3'b001; // blue
            default: rgb = 3'b000; // black
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_luma.sv
// Two-stage luma calculator: Y = (77R + 150G + 29B) >> 8.
// Stage 1 registers the three weighted products, stage 2 registers the
// scaled sum, so o_y lags the inputs by exactly two clocks.
// Ports:
//   i_clk, i_reset_n         - clock, asynchronous active-low reset
//   i_red, i_grn, i_blu      - source pixel, CW bits per channel
//   o_y                      - luma, CW bits
module vga_luma
    import vga_fx_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [CW-1:0] i_red,
    input  logic [CW-1:0] i_grn,
    input  logic [CW-1:0] i_blu,
    output logic [CW-1:0] o_y
);

    // Wide enough that no product or sum can overflow for any CW.
    localparam int AW = CW + 18;

    logic [AW-1:0] pr_q, pg_q, pb_q;
    logic [AW-1:0] pr_d, pg_d, pb_d;
    logic [CW-1:0] y_q, y_d;

    always_comb begin
        pr_d = AW'(LUMA_R) * AW'(i_red);
        pg_d = AW'(LUMA_G) * AW'(i_grn);
        pb_d = AW'(LUMA_B) * AW'(i_blu);
        // Weights sum to 256, so the shifted sum never exceeds 2^CW-1.
        y_d  = CW'((pr_q + pg_q + pb_q) >> 8);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pr_q <= '0;
            pg_q <= '0;
            pb_q <= '0;
            y_q  <= '0;
        end else begin
            pr_q <= pr_d;
            pg_q <= pg_d;
            pb_q <= pb_d;
            y_q  <= y_d;
        end
    end

    assign o_y = y_q;

endmodule

// File: rtl/vga_pixel_fx.sv
// Per-pixel video effects on a VGA-style stream.
// Three register stages: capture (s1), align with luma (s2), output mux.
// Syncs, enable and colour all emerge exactly three clocks after input.
// Ports:
//   i_clk, i_reset_n            - pixel clock, asynchronous active-low reset
//   i_hsync, i_vsync, i_de      - active-low syncs and active-video enable
//   i_red, i_grn, i_blu         - source pixel
//   i_mode                      - requested effect, applied at next frame edge
//   i_thresh, i_chk_lg, i_bar_w - effect parameters, sampled with the pixel
//   o_hsync, o_vsync, o_de      - delayed syncs / enable
//   o_red, o_grn, o_blu         - processed pixel, zero while o_de is low
//   o_mode                      - mode currently applied
//   o_frame, o_frame_stb        - frame count, pulse on delayed vsync fall
module vga_pixel_fx
    import vga_fx_pkg::*;
#(
    parameter int CW = 8,
    parameter int FW = 13,
    parameter int LW = 11
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [CW-1:0] i_red,
    input  logic [CW-1:0] i_grn,
    input  logic [CW-1:0] i_blu,
    input  logic [2:0]    i_mode,
    input  logic [CW-1:0] i_thresh,
    input  logic [2:0]    i_chk_lg,
    input  logic [FW-1:0] i_bar_w,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [CW-1:0] o_red,
    output logic [CW-1:0] o_grn,
    output logic [CW-1:0] o_blu,
    output logic [2:0]    o_mode,
    output logic [15:0]   o_frame,
    output logic          o_frame_stb
);

    // Everything the output mux needs about one pixel travels together.
    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          stb;
        logic          chk;
        logic          bar_zero;
        logic [2:0]    bar_idx;
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
        logic [CW-1:0] thr;
    } stage_t;

    logic          vs_prev_q, hs_prev_q, de_prev_q;
    logic [FW-1:0] col_q, col_d;
    logic [LW-1:0] row_q, row_d;
    logic [FW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [FW:0]   bar_nxt;
    fx_mode_e      pend_q, pend_d, mode_q, mode_d;
    logic          edge_q;
    logic [15:0]   frame_q, frame_d;
    stage_t        s1_q, s1_d, s2_q;
    logic          hs_q, vs_q, de_q, stb_q;
    logic [CW-1:0] red_q, grn_q, blu_q, red_d, grn_d, blu_d;
    logic [CW-1:0] luma_y;
    logic [2:0]    bar_c;
    logic          vs_fall, hs_fall, de_fall, col_max;

    // Luma is computed straight from the input so it lands beside s2.
    vga_luma #(.CW(CW)) u_luma (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_red     (i_red),
        .i_grn     (i_grn),
        .i_blu     (i_blu),
        .o_y       (luma_y)
    );

    // Input side: edge detection, position counters, bar tracking.
    always_comb begin
        vs_fall   = vs_prev_q & ~i_vsync;
        hs_fall   = hs_prev_q & ~i_hsync;
        de_fall   = de_prev_q & ~i_de;
        col_max   = (col_q == '1);
        col_d     = col_q;
        row_d     = row_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        bar_nxt   = {1'b0, bar_cnt_q} + (FW+1)'(1);

        if (!i_de)         col_d = '0;
        else if (!col_max) col_d = col_q + FW'(1);

        if (vs_fall)                      row_d = '0;
        else if (de_fall && row_q != '1)  row_d = row_q + LW'(1);

        // Running position inside the current bar replaces column / bar_w.
        // It freezes together with the column counter once that saturates.
        if (!i_de || hs_fall) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (!col_max) begin
            if (bar_nxt >= {1'b0, i_bar_w}) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_nxt[FW-1:0];
            end
        end

        s1_d.hs       = i_hsync;
        s1_d.vs       = i_vsync;
        s1_d.de       = i_de;
        s1_d.stb      = vs_fall;
        s1_d.chk      = (|(col_q & (FW'(1) << i_chk_lg))) ^
                        (|(row_q & (LW'(1) << i_chk_lg)));
        s1_d.bar_zero = (i_bar_w == '0);
        s1_d.bar_idx  = bar_idx_q;
        s1_d.r        = i_red;
        s1_d.g        = i_grn;
        s1_d.b        = i_blu;
        s1_d.thr      = i_thresh;

        // pend_q holds i_mode from the edge cycle itself when edge_q is set.
        pend_d  = fx_mode_e'(i_mode);
        mode_d  = edge_q ? pend_q : mode_q;
        frame_d = vs_fall ? frame_q + 16'd1 : frame_q;
    end

    // Output side: the mode mux sits here so one pixel sees one mode.
    always_comb begin
        bar_c = s2_q.bar_zero ? 3'b000 : bar_rgb(s2_q.bar_idx);
        red_d = s2_q.r;
        grn_d = s2_q.g;
        blu_d = s2_q.b;
        case (mode_q)
            MODE_INV: begin
                red_d = ~s2_q.r;
                grn_d = ~s2_q.g;
                blu_d = ~s2_q.b;
            end
            MODE_GRAY: begin
                red_d = luma_y;
                grn_d = luma_y;
                blu_d = luma_y;
            end
            MODE_THRESH: begin
                red_d = {CW{luma_y >= s2_q.thr}};
                grn_d = {CW{luma_y >= s2_q.thr}};
                blu_d = {CW{luma_y >= s2_q.thr}};
            end
            MODE_BARS: begin
                red_d = {CW{bar_c[2]}};
                grn_d = {CW{bar_c[1]}};
                blu_d = {CW{bar_c[0]}};
            end
            MODE_CHECK: begin
                red_d = {CW{s2_q.chk}};
                grn_d = {CW{s2_q.chk}};
                blu_d = {CW{s2_q.chk}};
            end
            default: ;
        endcase
        if (!s2_q.de) begin
            red_d = '0;
            grn_d = '0;
            blu_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vs_prev_q <= 1'b1;
            hs_prev_q <= 1'b1;
            de_prev_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pend_q    <= MODE_PASS;
            mode_q    <= MODE_PASS;
            edge_q    <= 1'b0;
            frame_q   <= '0;
            s1_q      <= '0;
            s1_q.hs   <= 1'b1;
            s1_q.vs   <= 1'b1;
            s2_q      <= '0;
            s2_q.hs   <= 1'b1;
            s2_q.vs   <= 1'b1;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            de_q      <= 1'b0;
            stb_q     <= 1'b0;
            red_q     <= '0;
            grn_q     <= '0;
            blu_q     <= '0;
        end else begin
            vs_prev_q <= i_vsync;
            hs_prev_q <= i_hsync;
            de_prev_q <= i_de;
            col_q     <= col_d;
            row_q     <= row_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            edge_q    <= vs_fall;
            frame_q   <= frame_d;
            s1_q      <= s1_d;
            s2_q      <= s1_q;
            hs_q      <= s2_q.hs;
            vs_q      <= s2_q.vs;
            de_q      <= s2_q.de;
            stb_q     <= s2_q.stb;
            red_q     <= red_d;
            grn_q     <= grn_d;
            blu_q     <= blu_d;
        end
    end

    assign o_hsync     = hs_q;
    assign o_vsync     = vs_q;
    assign o_de        = de_q;
    assign o_red       = red_q;
    assign o_grn       = grn_q;
    assign o_blu       = blu_q;
    assign o_mode      = mode_q;
    assign o_frame     = frame_q;
    assign o_frame_stb = stb_q;

endmodule

// File: tb/tb_vga_pixel_fx.sv
// Testbench for vga_pixel_fx: directed vectors with hand-computed results.
// Each driven cycle pushes its expected output word (stb, hs, vs, de, rgb)
// with the cycle it is due; a forked monitor pops and compares on negedges.
module tb_vga_pixel_fx;

    localparam int CW = 8;
    localparam int FW = 13;
    localparam int LW = 11;
    localparam int W  = 4 + 3 * CW;

    logic          clk;
    logic          rst_n;
    logic          i_hsync, i_vsync, i_de;
    logic [CW-1:0] i_red, i_grn, i_blu, i_thresh;
    logic [2:0]    i_mode, i_chk_lg;
    logic [FW-1:0] i_bar_w;
    logic          o_hsync, o_vsync, o_de, o_frame_stb;
    logic [CW-1:0] o_red, o_grn, o_blu;
    logic [2:0]    o_mode;
    logic [15:0]   o_frame;

    // Effect settings picked up by the driver on its next cycle.
    logic [2:0]    cfg_mode, cfg_chk_lg;
    logic [CW-1:0] cfg_thresh;
    logic [FW-1:0] cfg_bar_w;

    logic [W-1:0]  exp_q[$];
    int            due_q[$];
    int            cyc = 0;
    int            n_vec = 0;
    int            n_fail = 0;
    bit            mon_en;
    logic          prev_vs;
    logic [15:0]   exp_frame;
    logic [2:0]    bar_tab[8];

    vga_pixel_fx #(.CW(CW), .FW(FW), .LW(LW)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_hsync     (i_hsync),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .i_red       (i_red),
        .i_grn       (i_grn),
        .i_blu       (i_blu),
        .i_mode      (i_mode),
        .i_thresh    (i_thresh),
        .i_chk_lg    (i_chk_lg),
        .i_bar_w     (i_bar_w),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de),
        .o_red       (o_red),
        .o_grn       (o_grn),
        .o_blu       (o_blu),
        .o_mode      (o_mode),
        .o_frame     (o_frame),
        .o_frame_stb (o_frame_stb)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        logic [W-1:0] got;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (due_q.size() > 0 && due_q[0] <= cyc) begin
                    e = exp_q.pop_front();
                    void'(due_q.pop_front());
                    got = {o_frame_stb, o_hsync, o_vsync, o_de, o_red, o_grn, o_blu};
                    n_vec++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL pixel cyc%0d: got stb/hs/vs/de=%b rgb=%h, expected stb/hs/vs/de=%b rgb=%h",
                                 cyc, got[W-1 -: 4], got[3*CW-1:0], e[W-1 -: 4], e[3*CW-1:0]);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b,
                         input logic [CW-1:0] er, input logic [CW-1:0] eg, input logic [CW-1:0] eb);
        logic [CW-1:0] mr, mg, mb;
        @(negedge clk);
        i_hsync  = hs;
        i_vsync  = vs;
        i_de     = de;
        i_red    = r;
        i_grn    = g;
        i_blu    = b;
        i_mode   = cfg_mode;
        i_thresh = cfg_thresh;
        i_chk_lg = cfg_chk_lg;
        i_bar_w  = cfg_bar_w;
        mr = de ? er : {CW{1'b0}};
        mg = de ? eg : {CW{1'b0}};
        mb = de ? eb : {CW{1'b0}};
        exp_q.push_back({prev_vs & ~vs, hs, vs, de, mr, mg, mb});
        due_q.push_back(cyc + 3);
        prev_vs = vs;
    endtask

    task automatic pix(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b,
                       input logic [CW-1:0] er, input logic [CW-1:0] eg, input logic [CW-1:0] eb);
        drive(1'b1, 1'b1, 1'b1, r, g, b, er, eg, eb);
    endtask

    // Blanked cycles carry non-zero colour to prove it is forced to zero.
    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic line_gap();
        blank(1);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00);
        blank(2);
    endtask

    task automatic frame_edge();
        blank(1);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h77, 8'h66, 8'h55, 8'h00, 8'h00, 8'h00);
        blank(3);
        exp_frame = exp_frame + 16'd1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]    bc;
        logic          w;
        bar_tab = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        prev_vs    = 1'b1;
        exp_frame  = 16'h0000;
        cfg_mode   = 3'd0;
        cfg_thresh = 8'h00;
        cfg_chk_lg = 3'd3;
        cfg_bar_w  = 13'd80;
        i_hsync = 1'b1; i_vsync = 1'b1; i_de = 1'b0;
        i_red = '0; i_grn = '0; i_blu = '0;
        i_mode = '0; i_thresh = '0; i_chk_lg = '0; i_bar_w = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hsync", 32'(o_hsync), 32'd1);
        check("rst_vsync", 32'(o_vsync), 32'd1);
        check("rst_de",    32'(o_de),    32'd0);
        check("rst_rgb",   32'({o_red, o_grn, o_blu}), 32'd0);
        check("rst_mode",  32'(o_mode),  32'd0);
        check("rst_frame", 32'(o_frame), 32'd0);
        check("rst_stb",   32'(o_frame_stb), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Pass mode, with an hsync pulse to show sync delay
        blank(4);
        repeat (4) pix(8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56);
        line_gap();
        pix(8'hFF, 8'h80, 8'h01, 8'hFF, 8'h80, 8'h01);

        // Invert requested mid-frame: nothing changes until the frame edge
        cfg_mode = 3'd1;
        repeat (3) pix(8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56);
        check("mode_held", 32'(o_mode), 32'd0);
        line_gap();
        frame_edge();
        check("mode_inv",  32'(o_mode),  32'd1);
        check("frame_inc", 32'(o_frame), 32'(exp_frame));
        pix(8'h12, 8'h34, 8'h56, 8'hED, 8'hCB, 8'hA9);
        pix(8'h00, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hF0);

        // Gray
        cfg_mode = 3'd2;
        line_gap();
        frame_edge();
        check("mode_gray", 32'(o_mode), 32'd2);
        pix(8'hFF, 8'h00, 8'h00, 8'h4C, 8'h4C, 8'h4C);
        pix(8'h12, 8'h34, 8'h56, 8'h2D, 8'h2D, 8'h2D);
        pix(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // Threshold at and just above Y = 0x4C, and zero threshold on black
        cfg_mode = 3'd3;
        line_gap();
        frame_edge();
        cfg_thresh = 8'h4C;
        pix(8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        cfg_thresh = 8'h4D;
        pix(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        cfg_thresh = 8'h00;
        pix(8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);

        // Colour bars, 80 wide on a 640 line, then zero width
        cfg_mode = 3'd4;
        line_gap();
        frame_edge();
        for (int c = 0; c < 640; c++) begin
            bc = bar_tab[c / 80];
            pix(8'h55, 8'h55, 8'h55, {CW{bc[2]}}, {CW{bc[1]}}, {CW{bc[0]}});
        end
        line_gap();
        cfg_bar_w = 13'd0;
        for (int c = 0; c < 100; c++) pix(8'h55, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00);
        line_gap();

        // Checker, 8x8 squares, rows 0..8
        cfg_mode = 3'd5;
        frame_edge();
        check("mode_chk", 32'(o_mode), 32'd5);
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 16; c++) begin
                w = (((c ^ r) >> 3) & 1) != 0;
                pix(8'h33, 8'h33, 8'h33, {CW{w}}, {CW{w}}, {CW{w}});
            end
            line_gap();
        end
        for (int c = 0; c < 10; c++) begin
            w = (((c ^ 9) >> 3) & 1) != 0;
            pix(8'h33, 8'h33, 8'h33, {CW{w}}, {CW{w}}, {CW{w}});
        end

        // Asynchronous reset in the middle of an active line
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_de",    32'(o_de),    32'd0);
        check("arst_rgb",   32'({o_red, o_grn, o_blu}), 32'd0);
        check("arst_syncs", 32'({o_hsync, o_vsync}), 32'd3);
        check("arst_mode",  32'(o_mode),  32'd0);
        check("arst_frame", 32'(o_frame), 32'd0);
        exp_q.delete();
        due_q.delete();
        i_hsync = 1'b1; i_vsync = 1'b1; i_de = 1'b0;
        prev_vs   = 1'b1;
        exp_frame = 16'h0000;
        cfg_mode  = 3'd3;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // After release: pass mode until the frame edge applies the pending mode
        blank(4);
        pix(8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56);
        check("post_rst_mode", 32'(o_mode), 32'd0);
        line_gap();
        frame_edge();
        check("post_rst_apply", 32'(o_mode),  32'd3);
        check("post_rst_frame", 32'(o_frame), 32'(exp_frame));
        cfg_thresh = 8'h4D;
        pix(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Frame counter wrap from a preloaded value
        @(negedge clk);
        force dut.frame_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_q;
        exp_frame = 16'hFFFE;
        @(negedge clk);
        check("frame_preload", 32'(o_frame), 32'(exp_frame));
        frame_edge();
        check("frame_ffff", 32'(o_frame), 32'(exp_frame));
        frame_edge();
        check("frame_wrap", 32'(o_frame), 32'h0000);

        // Let the pipeline drain, bounded
        for (int i = 0; i < 10 && due_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (due_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", due_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
